mmio_ctrl: RTL and testbench

MMIO_CTRL -- requirements
Module: mmio_ctrl

---
 rtl/mmio_ctrl_pkg.sv | 21 ++
 rtl/mmio_ctrl_io_counter.sv | 31 +++
 rtl/mmio_ctrl.sv | 110 +++++++++++
 tb/tb_mmio_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mmio_ctrl_pkg
//  Desc   : Shared IO window base and register offsets for decode/writeback.
//  Rev    : 1.0  initial release
// ============================================================================
package mmio_ctrl_pkg;

    typedef logic [27:0] io_off_t;

    localparam logic [31:0] c_IO_BASE_DEFAULT = 32'h8000_0000;

    localparam io_off_t c_OFF_CTRL = 28'h000_0000;
    localparam io_off_t c_OFF_RX   = 28'h000_0004;
    localparam io_off_t c_OFF_TX   = 28'h000_0008;
    localparam io_off_t c_OFF_CYC  = 28'h000_0010;
    localparam io_off_t c_OFF_INST = 28'h000_0014;
    localparam io_off_t c_OFF_CRST = 28'h000_0018;

endpackage
`default_nettype wire

// File: rtl/mmio_ctrl_io_counter.sv
`default_nettype none
// ============================================================================
//  Module : io_counter
//  Desc   : Free-running wrap-around counter with synchronous clear.
//  Rev    : 1.0  initial release
// ============================================================================
module io_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Clear takes precedence over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/mmio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : mmio_ctrl
//  Desc   : Memory-mapped IO block: UART RX/TX registers and perf counters.
//  Rev    : 1.0  initial release
// ============================================================================
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE   = c_IO_BASE_DEFAULT,
    parameter int          CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retire,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] io_rdata,
    output logic        io_sel
);

    logic                 w_hit;
    io_off_t              w_off;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_tx_wr;
    logic                 w_cnt_clr;
    logic [31:0]          w_rdata_nxt;
    logic [CNT_WIDTH-1:0] w_cyc;
    logic [CNT_WIDTH-1:0] w_inst;
    logic                 w_unused;

    logic [31:0]          r_io_rdata;
    logic                 r_io_sel;
    logic [7:0]           r_tx_data;
    logic                 r_tx_valid;

    assign w_hit    = (addr[31:28] == IO_BASE[31:28]);
    assign w_off    = addr[27:0];
    assign w_wr     = we && w_hit;
    // A store wins over a simultaneous load, so the load side effects are masked.
    assign w_rd     = re && w_hit && !we;
    assign w_tx_wr  = w_wr && (w_off == c_OFF_TX) && !r_tx_valid;
    assign w_cnt_clr = w_wr && (w_off == c_OFF_CRST);
    assign w_unused = &{1'b0, wdata[31:8]};

    assign rx_ready = !rst && w_rd && (w_off == c_OFF_RX) && rx_valid;

    always_comb begin
        w_rdata_nxt = '0;
        if (w_rd) begin
            case (w_off)
                c_OFF_CTRL: w_rdata_nxt = {30'b0, rx_valid, !r_tx_valid};
                c_OFF_RX:   w_rdata_nxt = {24'b0, rx_data};
                c_OFF_CYC:  w_rdata_nxt = 32'(w_cyc);
                c_OFF_INST: w_rdata_nxt = 32'(w_inst);
                default:    w_rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_io_rdata <= '0;
            r_io_sel   <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_io_rdata <= w_rdata_nxt;
            r_io_sel   <= w_hit && re;
            if (w_tx_wr) begin
                r_tx_data  <= wdata[7:0];
                r_tx_valid <= 1'b1;
            end else if (r_tx_valid && tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    io_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (1'b1),
        .i_clr (w_cnt_clr),
        .o_cnt (w_cyc)
    );

    io_counter #(.CNT_WIDTH(CNT_WIDTH)) u_inst_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (inst_retire),
        .i_clr (w_cnt_clr),
        .o_cnt (w_inst)
    );

    assign io_rdata = r_io_rdata;
    assign io_sel   = r_io_sel;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_mmio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_mmio_ctrl
//  Desc   : Scenario and randomized checks of mmio_ctrl against a reference model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic        inst_retire = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [31:0] io_rdata;
    logic        io_sel;

    // Second instance with a narrow counter to observe wrap-around quickly.
    logic        w2_rx_ready;
    logic [7:0]  w2_tx_data;
    logic        w2_tx_valid;
    logic [31:0] w2_rdata;
    logic        w2_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_ctrl u_dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .inst_retire(inst_retire), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .io_rdata(io_rdata), .io_sel(io_sel)
    );

    mmio_ctrl #(.IO_BASE(32'h8000_0000), .CNT_WIDTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .addr(32'h8000_0010), .wdata(32'h0), .we(1'b0),
        .re(1'b1), .inst_retire(1'b0), .rx_data(8'h00), .rx_valid(1'b0),
        .rx_ready(w2_rx_ready), .tx_data(w2_tx_data), .tx_valid(w2_tx_valid),
        .tx_ready(1'b0), .io_rdata(w2_rdata), .io_sel(w2_sel)
    );

    // ---------------- reference model ----------------
    int unsigned m_cyc;       // cycles since reset / last clear, mod 2^32
    int unsigned m_ins;       // retired instructions since reset / last clear
    bit          m_tx_full;
    logic [7:0]  m_tx_byte;
    logic [31:0] m_rdata;
    bit          m_sel;
    int          m2_cnt;
    int          m2_exp;

    function automatic bit in_window(input logic [31:0] a);
        return a[31:28] == 4'h8;
    endfunction

    function automatic logic [31:0] pred_rdata();
        if (!(in_window(addr) && re && !we)) return 32'h0;
        case (addr[27:0])
            28'h00:  return {30'b0, rx_valid, !m_tx_full};
            28'h04:  return {24'b0, rx_data};
            28'h10:  return m_cyc;
            28'h14:  return m_ins;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_rx_ready();
        return !rst && re && !we && in_window(addr) && (addr[27:0] == 28'h04) && rx_valid;
    endfunction

    function automatic bit is_clear();
        return we && in_window(addr) && (addr[27:0] == 28'h18);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cyc <= 0; m_ins <= 0; m_tx_full <= 0; m_tx_byte <= 8'h00;
            m_rdata <= 32'h0; m_sel <= 0; m2_cnt <= 0; m2_exp <= 0;
        end else begin
            m_rdata <= pred_rdata();
            m_sel   <= in_window(addr) && re;
            m_cyc   <= is_clear() ? 0 : m_cyc + 1;
            m_ins   <= is_clear() ? 0 : m_ins + (inst_retire ? 1 : 0);
            if (we && in_window(addr) && addr[27:0] == 28'h08 && !m_tx_full) begin
                m_tx_full <= 1; m_tx_byte <= wdata[7:0];
            end else if (m_tx_full && tx_ready) begin
                m_tx_full <= 0;
            end
            m2_exp <= m2_cnt;
            m2_cnt <= (m2_cnt + 1) % 16;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic r, input logic ir, input logic rv,
                         input logic [7:0] rd, input logic tr);
        addr = a; wdata = d; we = w; re = r; inst_retire = ir;
        rx_valid = rv; rx_data = rd; tx_ready = tr;
        #1;
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(32'h8000_0004, 32'h55, 0, 1, 1, 1, 8'h77, 0);
            checks++;
            if (rx_ready !== 1'b0) begin
                errors++; $display("FAIL reset_rx_ready: got %b exp 0", rx_ready);
            end
        end
        tick();
        checks++;
        if (io_rdata !== 32'h0 || io_sel !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%h sel=%b txv=%b txd=%h exp all 0",
                     io_rdata, io_sel, tx_valid, tx_data);
        end
    endtask

    task automatic test_cycle_read();
        rst = 1'b0;
        idle();
        tick(); tick(); tick();
        drive(32'h8000_0010, 32'h0, 0, 1, 0, 0, 8'h00, 0);
        tick();
        checks++;
        if (io_rdata !== m_rdata || io_sel !== 1'b1 || m_rdata != 32'd3) begin
            errors++;
            $display("FAIL cycle_read: got rdata=%0d sel=%b exp rdata=%0d (3) sel=1",
                     io_rdata, io_sel, m_rdata);
        end
    endtask

    task automatic test_tx();
        drive(32'h8000_0008, 32'hFFFF_FF41, 1, 0, 0, 0, 8'h00, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) drive(32'h8000_0008, 32'h42, 1, 0, 0, 0, 8'h00, 0);
            else idle();
            tick();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h41 || m_tx_byte !== 8'h41) begin
                errors++;
                $display("FAIL tx_hold[%0d]: got txv=%b txd=%h exp txv=1 txd=41", i, tx_valid, tx_data);
            end
        end
        drive(32'h8000_0000, 32'h0, 0, 1, 0, 0, 8'h00, 1);
        tick();
        checks++;
        if (tx_valid !== 1'b0 || io_rdata !== 32'h0000_0000) begin
            errors++;
            $display("FAIL tx_handshake: got txv=%b ctrl=%h exp txv=0 ctrl=0", tx_valid, io_rdata);
        end
        drive(32'h8000_0000, 32'h0, 0, 1, 0, 0, 8'h00, 0);
        tick();
        checks++;
        if (io_rdata !== 32'h0000_0001) begin
            errors++; $display("FAIL tx_empty_ctrl: got %h exp 00000001", io_rdata);
        end
    endtask

    task automatic test_rx();
        drive(32'h8000_0004, 32'h0, 0, 1, 0, 1, 8'h5A, 0);
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++; $display("FAIL rx_ready_pulse: got %b exp 1", rx_ready);
        end
        tick();
        idle();
        checks++;
        if (io_rdata !== 32'h0000_005A || io_sel !== 1'b1 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL rx_data: got rdata=%h sel=%b rdy=%b exp 0000005a 1 0", io_rdata, io_sel, rx_ready);
        end
        drive(32'h8000_0004, 32'h0, 0, 1, 0, 0, 8'hC3, 0);
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++; $display("FAIL rx_no_valid_ready: got %b exp 0", rx_ready);
        end
        tick();
        checks++;
        if (io_rdata !== 32'h0000_00C3) begin
            errors++; $display("FAIL rx_no_valid_data: got %h exp 000000c3", io_rdata);
        end
    endtask

    task automatic test_counter_clear();
        for (int i = 0; i < 7; i++) begin
            drive(32'h0, 32'h0, 0, 0, 1, 0, 8'h00, 0);
            tick();
            idle();
            tick();
        end
        drive(32'h8000_0014, 32'h0, 0, 1, 0, 0, 8'h00, 0);
        tick();
        checks++;
        if (io_rdata !== m_rdata || m_rdata < 32'd7) begin
            errors++; $display("FAIL inst_count: got %0d exp %0d", io_rdata, m_rdata);
        end
        drive(32'h8000_0018, 32'h0, 1, 0, 1, 0, 8'h00, 0);
        tick();
        drive(32'h8000_0014, 32'h0, 0, 1, 0, 0, 8'h00, 0);
        tick();
        checks++;
        if (io_rdata !== 32'h0) begin
            errors++; $display("FAIL inst_after_clear: got %0d exp 0", io_rdata);
        end
        drive(32'h8000_0010, 32'h0, 0, 1, 1, 0, 8'h00, 0);
        tick();
        checks++;
        if (io_rdata !== 32'd1) begin
            errors++; $display("FAIL cyc_after_clear: got %0d exp 1", io_rdata);
        end
        drive(32'h0, 32'h0, 0, 0, 1, 0, 8'h00, 0);
        tick();
        drive(32'h8000_0014, 32'h0, 0, 1, 0, 0, 8'h00, 0);
        tick();
        checks++;
        if (io_rdata !== 32'd2 || m_rdata != 32'd2) begin
            errors++; $display("FAIL inst_recount: got %0d exp 2", io_rdata);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] a_tab [4];
        a_tab[0] = 32'h8000_0020; a_tab[1] = 32'h8000_0008;
        a_tab[2] = 32'h8000_0018; a_tab[3] = 32'h8000_0011;
        for (int i = 0; i < 4; i++) begin
            drive(a_tab[i], 32'h0, 0, 1, 0, 1, 8'hAA, 0);
            tick();
            checks++;
            if (io_rdata !== 32'h0 || io_sel !== 1'b1) begin
                errors++;
                $display("FAIL unmapped[%h]: got rdata=%h sel=%b exp 0 1", a_tab[i], io_rdata, io_sel);
            end
        end
        drive(32'h1000_0004, 32'h0, 0, 1, 0, 1, 8'hAA, 0);
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++; $display("FAIL miss_rx_ready: got %b exp 0", rx_ready);
        end
        tick();
        checks++;
        if (io_sel !== 1'b0 || io_rdata !== 32'h0) begin
            errors++; $display("FAIL miss_sel: got sel=%b rdata=%h exp 0 0", io_sel, io_rdata);
        end
        drive(32'h1000_0008, 32'h99, 1, 0, 0, 0, 8'h00, 0);
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL miss_tx_write: got txv=%b exp 0", tx_valid);
        end
    endtask

    task automatic test_we_re_priority();
        drive(32'h8000_0008, 32'h3C, 1, 1, 0, 1, 8'h11, 0);
        tick();
        idle();
        checks++;
        if (io_rdata !== 32'h0 || io_sel !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
            errors++;
            $display("FAIL we_re_tx: got rdata=%h sel=%b txv=%b txd=%h exp 0 1 1 3c",
                     io_rdata, io_sel, tx_valid, tx_data);
        end
        drive(32'h8000_0004, 32'h0, 1, 1, 0, 1, 8'h11, 1);
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++; $display("FAIL we_re_rx_ready: got %b exp 0", rx_ready);
        end
        tick();
        checks++;
        if (io_rdata !== 32'h0 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL we_re_rx_data: got rdata=%h txv=%b exp 0 0", io_rdata, tx_valid);
        end
    endtask

    task automatic test_wrap();
        bit saw_wrap = 0;
        int prev = -1;
        idle();
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (w2_rdata !== 32'(m2_exp)) begin
                errors++; $display("FAIL wrap_cnt[%0d]: got %0d exp %0d", i, w2_rdata, m2_exp);
            end
            if (prev == 15 && w2_rdata == 32'h0) saw_wrap = 1;
            prev = int'(w2_rdata);
        end
        checks++;
        if (!saw_wrap) begin
            errors++; $display("FAIL wrap_seen: got 0 exp 1 (15 -> 0 transition)");
        end
    endtask

    task automatic test_random();
        logic [27:0] off_tab [7];
        logic [31:0] a;
        off_tab[0] = 28'h00; off_tab[1] = 28'h04; off_tab[2] = 28'h08; off_tab[3] = 28'h10;
        off_tab[4] = 28'h14; off_tab[5] = 28'h18; off_tab[6] = 28'h1C;
        for (int i = 0; i < 400; i++) begin
            a = {($urandom_range(0, 9) < 8) ? 4'h8 : 4'($urandom_range(0, 7)),
                 off_tab[$urandom_range(0, 6)]};
            drive(a, $urandom, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6),
                  1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 9) < 3));
            checks++;
            if (rx_ready !== exp_rx_ready()) begin
                errors++; $display("FAIL rand_rx_ready[%0d]: got %b exp %b", i, rx_ready, exp_rx_ready());
            end
            tick();
            checks++;
            if (io_rdata !== m_rdata || io_sel !== m_sel || tx_valid !== m_tx_full || tx_data !== m_tx_byte) begin
                errors++;
                $display("FAIL rand_out[%0d]: got rdata=%h sel=%b txv=%b txd=%h exp %h %b %b %h",
                         i, io_rdata, io_sel, tx_valid, tx_data, m_rdata, m_sel, m_tx_full, m_tx_byte);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(32'h8000_0008, 32'hE7, 1, 0, 0, 0, 8'h00, 0);
        tick();
        drive(32'h8000_0010, 32'h0, 0, 1, 1, 0, 8'h00, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        checks++;
        if (tx_valid !== 1'b0 || io_sel !== 1'b0 || io_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got txv=%b sel=%b rdata=%h exp 0 0 0", tx_valid, io_sel, io_rdata);
        end
        drive(32'h8000_0014, 32'h0, 0, 1, 0, 0, 8'h00, 0);
        tick();
        checks++;
        if (io_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_mid_inst: got %0d exp 0", io_rdata);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_cycle_read();
        test_tx();
        test_rx();
        test_counter_clear();
        test_unmapped();
        test_we_re_priority();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
